// File: rtl/crc_sched_pkg.sv
// rtl/crc_sched_pkg.sv - shared types and constants for the CRC job scheduler
package crc_sched_pkg;

    // Job sequencing states. One word is serialised as four byte states.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_B0,
        ST_B1,
        ST_B2,
        ST_B3,
        ST_FLUSH,
        ST_DONE
    } state_t;

    localparam logic [31:0] CRC_XOROUT     = 32'hFFFF_FFFF;
    localparam int          BYTES_PER_WORD = 4;
    localparam int          TIMEOUT_W      = 8;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first request at or after ptr
//
// Ports:
//   req    in   NREQ  request vector
//   ptr    in   IDW   highest-priority index
//   grant  out  NREQ  one-hot grant (all zero when no request)
//   id     out  IDW   encoded grant index
module rr_arbiter
    import crc_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  id
);

    always_comb begin : pick
        logic found;
        int   idx;
        grant = '0;
        id    = '0;
        found = 1'b0;
        idx   = 0;
        // Scan NREQ positions starting at ptr; modulo handles non power-of-two NREQ.
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                id         = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/crc_job_sched.sv
// rtl/crc_job_sched.sv - round-robin job scheduler sharing one byte-serial CRC32 engine
//
// Ports:
//   clock, resetn           clock and synchronous active-low reset
//   req_valid/data/last     per-requester word streams (word i on req_data[i*32+:32])
//   req_ready               word accept, only ever set for the granted requester
//   res_valid/ready         result handshake, result held until accepted
//   res_id/crc/err          requester id, final CRC, timeout-abort flag
//   busy                    scheduler not idle
//   crc_clear/enable/data   control and byte stream to the CRC engine
//   crc_value               engine running CRC (registered in the engine)
module crc_job_sched
    import crc_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDW     = $clog2(NREQ),
    parameter int TIMEOUT = 255
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*32-1:0] req_data,
    input  logic [NREQ-1:0]    req_last,
    output logic [NREQ-1:0]    req_ready,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [IDW-1:0]     res_id,
    output logic [31:0]        res_crc,
    output logic               res_err,
    output logic               busy,
    output logic               crc_clear,
    output logic               crc_enable,
    output logic [7:0]         crc_data,
    input  logic [31:0]        crc_value
);

    localparam int                   WORD_W  = 8 * BYTES_PER_WORD;
    localparam logic [TIMEOUT_W-1:0] TMO_MAX = TIMEOUT_W'(TIMEOUT);

    state_t               state_q, state_d;
    logic [IDW-1:0]       grant_id_q, grant_id_d;
    logic [NREQ-1:0]      grant_oh_q, grant_oh_d;
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [WORD_W-1:0]    word_q, word_d;
    logic                 last_q, last_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic [31:0]          res_crc_q, res_crc_d;
    logic [IDW-1:0]       res_id_q, res_id_d;
    logic                 res_err_q, res_err_d;

    logic [NREQ-1:0]      arb_oh;
    logic [IDW-1:0]       arb_id;
    logic [WORD_W-1:0]    sel_data;
    logic                 sel_valid;
    logic                 sel_last;
    logic                 word_hs;
    logic                 tmo_hit;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (arb_oh),
        .id    (arb_id)
    );

    // The locked one-hot grant masks every other requester for the whole job.
    assign sel_valid = |(req_valid & grant_oh_q);
    assign sel_last  = |(req_last & grant_oh_q);
    assign word_hs   = (state_q == ST_LOAD) && sel_valid;
    assign tmo_hit   = (tmo_q == TMO_MAX);

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_oh_q[i]) sel_data = req_data[i*WORD_W +: WORD_W];
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            grant_id_q <= '0;
            grant_oh_q <= '0;
            rr_ptr_q   <= '0;
            word_q     <= '0;
            last_q     <= 1'b0;
            tmo_q      <= '0;
            res_crc_q  <= '0;
            res_id_q   <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            grant_oh_q <= grant_oh_d;
            rr_ptr_q   <= rr_ptr_d;
            word_q     <= word_d;
            last_q     <= last_d;
            tmo_q      <= tmo_d;
            res_crc_q  <= res_crc_d;
            res_id_q   <= res_id_d;
            res_err_q  <= res_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (|req_valid) state_d = ST_CLEAR;
            ST_CLEAR: state_d = ST_LOAD;
            ST_LOAD: begin
                if (word_hs)      state_d = ST_B0;
                else if (tmo_hit) state_d = ST_DONE;
            end
            ST_B0:    state_d = ST_B1;
            ST_B1:    state_d = ST_B2;
            ST_B2:    state_d = ST_B3;
            ST_B3:    state_d = last_q ? ST_FLUSH : ST_LOAD;
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  if (res_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_id_d = grant_id_q;
        grant_oh_d = grant_oh_q;
        rr_ptr_d   = rr_ptr_q;
        word_d     = word_q;
        last_d     = last_q;
        tmo_d      = tmo_q;
        res_crc_d  = res_crc_q;
        res_id_d   = res_id_q;
        res_err_d  = res_err_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    grant_id_d = arb_id;
                    grant_oh_d = arb_oh;
                end
            end
            ST_CLEAR: tmo_d = '0;
            ST_LOAD: begin
                if (word_hs) begin
                    word_d = sel_data;
                    last_d = sel_last;
                    tmo_d  = '0;
                end else if (tmo_hit) begin
                    // Abort: report whatever the engine has accumulated so far.
                    res_crc_d = crc_value ^ CRC_XOROUT;
                    res_id_d  = grant_id_q;
                    res_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TIMEOUT_W'(1);
                end
            end
            ST_FLUSH: begin
                res_crc_d = crc_value ^ CRC_XOROUT;
                res_id_d  = grant_id_q;
                res_err_d = 1'b0;
            end
            ST_DONE: begin
                if (res_ready) begin
                    rr_ptr_d = (grant_id_q == IDW'(NREQ - 1)) ? '0 : grant_id_q + IDW'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == ST_LOAD) ? (grant_oh_q & req_valid) : '0;
        res_valid  = (state_q == ST_DONE);
        busy       = (state_q != ST_IDLE);
        crc_clear  = (state_q == ST_CLEAR);
        crc_enable = 1'b0;
        crc_data   = '0;
        case (state_q)
            ST_B0: begin crc_enable = 1'b1; crc_data = word_q[7:0];   end
            ST_B1: begin crc_enable = 1'b1; crc_data = word_q[15:8];  end
            ST_B2: begin crc_enable = 1'b1; crc_data = word_q[23:16]; end
            ST_B3: begin crc_enable = 1'b1; crc_data = word_q[31:24]; end
            default: ;
        endcase
    end

    assign res_crc = res_crc_q;
    assign res_id  = res_id_q;
    assign res_err = res_err_q;

endmodule

// File: tb/tb_crc_job_sched.sv
// tb/tb_crc_job_sched.sv - self-checking bench for crc_job_sched with an attached CRC32 engine
module tb_crc_job_sched;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 255;

    logic               clock = 1'b0;
    logic               resetn = 1'b0;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ*32-1:0] req_data = '0;
    logic [NREQ-1:0]    req_last = '0;
    logic [NREQ-1:0]    req_ready;
    logic               res_valid;
    logic               res_ready = 1'b1;
    logic [IDW-1:0]     res_id;
    logic [31:0]        res_crc;
    logic               res_err;
    logic               busy;
    logic               crc_clear;
    logic               crc_enable;
    logic [7:0]         crc_data;
    logic [31:0]        crc_value;

    crc_job_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .resetn(resetn),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_crc(res_crc),
        .res_err(res_err), .busy(busy),
        .crc_clear(crc_clear), .crc_enable(crc_enable), .crc_data(crc_data), .crc_value(crc_value)
    );

    always #5 clock = ~clock;

    // Byte-serial reflected CRC32 engine (crc_acc behaviour), not reset by resetn.
    function automatic logic [31:0] eng_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    logic [31:0] eng_crc = 32'hFFFF_FFFF;
    always @(posedge clock) begin
        if (crc_clear)       eng_crc <= 32'hFFFF_FFFF;
        else if (crc_enable) eng_crc <= eng_byte(eng_crc, crc_data);
    end
    assign crc_value = eng_crc;

    // Reference: whole-word CRC32 update, bits consumed LSB first (same as bytes LSB first).
    function automatic logic [31:0] ref_word(input logic [31:0] c, input logic [31:0] w);
        logic [31:0] r;
        r = c ^ w;
        for (int k = 0; k < 32; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    typedef struct { logic [31:0] data; logic last; int gap; } word_t;
    typedef struct { int id; logic [31:0] crc; logic err; } res_t;

    word_t           rq[NREQ][$];
    int              gap_cnt[NREQ];
    res_t            res_q[$];
    res_t            exp_q[$];
    logic [NREQ-1:0] hs = '0;
    int              en_cnt = 0;
    int              clr_cnt = 0;
    int              n_chk = 0;
    int              n_fail = 0;

    // Requester/consumer driver: inputs change on negedge, handshakes sampled just before posedge.
    always begin
        @(negedge clock);
        for (int i = 0; i < NREQ; i++) begin
            if (hs[i] && rq[i].size() != 0) begin
                void'(rq[i].pop_front());
                gap_cnt[i] = 0;
            end
            if (rq[i].size() != 0 && gap_cnt[i] >= rq[i][0].gap) begin
                req_valid[i]          = 1'b1;
                req_data[i*32 +: 32]  = rq[i][0].data;
                req_last[i]           = rq[i][0].last;
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*32 +: 32]  = '0;
                req_last[i]           = 1'b0;
                if (rq[i].size() != 0) gap_cnt[i]++;
            end
        end
        #4;
        hs = resetn ? (req_valid & req_ready) : '0;
        en_cnt  += int'(crc_enable);
        clr_cnt += int'(crc_clear);
        if (resetn && res_valid && res_ready) res_q.push_back('{int'(res_id), res_crc, res_err});
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_word(input int r, input logic [31:0] d, input logic l, input int g);
        rq[r].push_back('{d, l, g});
    endtask

    // Random job for requester r; returns the finalised expected CRC.
    task automatic build_job(input int r, input int nw, input int gmax, output logic [31:0] crc);
        logic [31:0] c;
        logic [31:0] d;
        c = 32'hFFFF_FFFF;
        for (int k = 0; k < nw; k++) begin
            d = $urandom;
            push_word(r, d, (k == nw - 1), (k == 0) ? 0 : int'($urandom_range(0, gmax)));
            c = ref_word(c, d);
        end
        crc = ~c;
    endtask

    task automatic flush_tb();
        for (int i = 0; i < NREQ; i++) begin
            rq[i].delete();
            gap_cnt[i] = 0;
        end
        res_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        res_ready = 1'b1;
        repeat (2) tick();
        flush_tb();
        repeat (2) tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic wait_results(input int n, input int budget, input string name);
        int c;
        c = 0;
        while (res_q.size() < n && c < budget) begin
            tick();
            c++;
        end
        n_chk++;
        if (res_q.size() < n) begin
            $display("FAIL %s_timeout: got %0d results, want %0d", name, res_q.size(), n);
            n_fail++;
        end
    endtask

    // Compare collected results against exp_q in order.
    task automatic check_results(input string name);
        for (int k = 0; k < exp_q.size() && k < res_q.size(); k++) begin
            n_chk++;
            if (res_q[k].id !== exp_q[k].id || res_q[k].crc !== exp_q[k].crc || res_q[k].err !== exp_q[k].err) begin
                $display("FAIL %s[%0d]: got id=%0d crc=%h err=%b want id=%0d crc=%h err=%b", name, k,
                         res_q[k].id, res_q[k].crc, res_q[k].err, exp_q[k].id, exp_q[k].crc, exp_q[k].err);
                n_fail++;
            end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        n_chk++;
        if (req_ready !== '0 || res_valid !== 1'b0 || res_id !== '0 || res_crc !== '0 || res_err !== 1'b0 ||
            busy !== 1'b0 || crc_clear !== 1'b0 || crc_enable !== 1'b0 || crc_data !== '0) begin
            $display("FAIL %s: got rdy=%b rv=%b id=%0d crc=%h err=%b busy=%b clr=%b en=%b data=%h want all 0",
                     name, req_ready, res_valid, res_id, res_crc, res_err, busy, crc_clear, crc_enable, crc_data);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        flush_tb();
        repeat (3) tick();
        check_idle_outputs("reset_state");
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_single(input string name);
        res_q.delete();
        exp_q.delete();
        en_cnt  = 0;
        clr_cnt = 0;
        push_word(0, 32'h34333231, 1'b1, 0);
        exp_q.push_back('{0, 32'h9BE3E0A3, 1'b0});
        wait_results(1, 200, name);
        check_results(name);
        repeat (2) tick();
        n_chk++;
        if (en_cnt !== 4) begin
            $display("FAIL %s_enable_cycles: got %0d want 4", name, en_cnt);
            n_fail++;
        end
        n_chk++;
        if (clr_cnt !== 1 || busy !== 1'b0) begin
            $display("FAIL %s_clear_busy: got clear=%0d busy=%b want clear=1 busy=0", name, clr_cnt, busy);
            n_fail++;
        end
    endtask

    task automatic test_rr_order();
        logic [31:0] c1a, c1b, c2, c3;
        do_reset();
        build_job(1, 2, 0, c1a);
        build_job(1, 1, 0, c1b);
        build_job(2, 1, 0, c2);
        build_job(3, 3, 0, c3);
        exp_q.push_back('{1, c1a, 1'b0});
        exp_q.push_back('{2, c2, 1'b0});
        exp_q.push_back('{3, c3, 1'b0});
        exp_q.push_back('{1, c1b, 1'b0});
        wait_results(4, 2000, "rr_order");
        check_results("rr_order");
    endtask

    task automatic test_gap();
        logic [31:0] w0, w1, c;
        w0 = $urandom;
        w1 = $urandom;
        c  = ~ref_word(ref_word(32'hFFFF_FFFF, w0), w1);
        res_q.delete();
        exp_q.delete();
        push_word(0, w0, 1'b0, 0);
        push_word(0, w1, 1'b1, 0);
        exp_q.push_back('{0, c, 1'b0});
        push_word(0, w0, 1'b0, 0);
        push_word(0, w1, 1'b1, 10);
        exp_q.push_back('{0, c, 1'b0});
        wait_results(2, 400, "gap");
        check_results("gap");
    endtask

    task automatic test_timeout();
        logic [31:0] w0, w1;
        w0 = $urandom;
        w1 = $urandom;
        res_q.delete();
        exp_q.delete();
        push_word(2, w0, 1'b0, 0);
        push_word(2, w1, 1'b1, 300);
        exp_q.push_back('{2, ~ref_word(32'hFFFF_FFFF, w0), 1'b1});
        exp_q.push_back('{2, ~ref_word(32'hFFFF_FFFF, w1), 1'b0});
        wait_results(2, 1500, "timeout");
        check_results("timeout");
    endtask

    task automatic test_backpressure();
        logic [31:0] ca, cb;
        int c;
        do_reset();
        res_ready = 1'b0;
        build_job(0, 1, 0, ca);
        build_job(1, 2, 0, cb);
        exp_q.push_back('{0, ca, 1'b0});
        exp_q.push_back('{1, cb, 1'b0});
        c = 0;
        while (res_valid !== 1'b1 && c < 200) begin
            tick();
            c++;
        end
        n_chk++;
        if (res_valid !== 1'b1) begin
            $display("FAIL bp_first_result: got res_valid=%b want 1", res_valid);
            n_fail++;
        end
        clr_cnt = 0;
        repeat (20) begin
            tick();
            n_chk++;
            if (res_valid !== 1'b1 || int'(res_id) !== 0 || res_crc !== ca || res_err !== 1'b0 || req_ready !== '0) begin
                $display("FAIL bp_hold: got rv=%b id=%0d crc=%h err=%b rdy=%b want rv=1 id=0 crc=%h err=0 rdy=0",
                         res_valid, res_id, res_crc, res_err, req_ready, ca);
                n_fail++;
            end
        end
        n_chk++;
        if (clr_cnt !== 0) begin
            $display("FAIL bp_no_clear: got %0d clears want 0", clr_cnt);
            n_fail++;
        end
        res_ready = 1'b1;
        wait_results(2, 300, "bp");
        check_results("bp");
    endtask

    task automatic test_reset_mid_job();
        int c;
        res_q.delete();
        exp_q.delete();
        en_cnt = 0;
        push_word(0, 32'h34333231, 1'b1, 0);
        c = 0;
        while (en_cnt < 2 && c < 100) begin
            tick();
            c++;
        end
        n_chk++;
        if (crc_enable !== 1'b1 || crc_data !== 8'h33) begin
            $display("FAIL midrst_b2: got en=%b data=%h want en=1 data=33", crc_enable, crc_data);
            n_fail++;
        end
        resetn = 1'b0;
        tick();
        check_idle_outputs("midrst_outputs");
        flush_tb();
        tick();
        resetn = 1'b1;
        tick();
        n_chk++;
        if (res_q.size() !== 0) begin
            $display("FAIL midrst_no_result: got %0d results want 0", res_q.size());
            n_fail++;
        end
        test_single("midrst_rerun");
    endtask

    task automatic test_random();
        logic [31:0] exp_r[NREQ][$];
        logic [31:0] c;
        int remaining;
        int ptr;
        for (int round = 0; round < 3; round++) begin
            do_reset();
            remaining = 0;
            for (int r = 0; r < NREQ; r++) begin
                int nj;
                nj = $urandom_range(0, 2);
                if (r == round) nj = nj + 1;
                for (int j = 0; j < nj; j++) begin
                    build_job(r, $urandom_range(1, 3), 3, c);
                    exp_r[r].push_back(c);
                    remaining++;
                end
            end
            // Every requester's jobs are queued up front, so the order is pure round robin.
            ptr = 0;
            while (remaining > 0) begin
                for (int k = 0; k < NREQ; k++) begin
                    int idx;
                    idx = (ptr + k) % NREQ;
                    if (exp_r[idx].size() != 0) begin
                        exp_q.push_back('{idx, exp_r[idx].pop_front(), 1'b0});
                        ptr = (idx + 1) % NREQ;
                        remaining--;
                        break;
                    end
                end
            end
            wait_results(exp_q.size(), 4000, "random");
            check_results("random");
        end
    endtask

    initial begin
        test_reset();
        test_single("single");
        test_rr_order();
        test_gap();
        test_timeout();
        test_backpressure();
        test_reset_mid_job();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
